// File: rtl/sample_delay_tap_pkg.sv
// -----------------------------------------------------------------------------
// sample_delay_tap_pkg
// Shared audio definitions for the delay/echo sample path.
//   SAMPLE_WIDTH : default sample width (two's complement audio)
//   DELAY_DEPTH  : default delay-line length in samples (power of two)
//   sample_t     : one audio sample at the default width
//   tap_sel_e    : output source chosen for a strobe, resolved one cycle early
// -----------------------------------------------------------------------------
package sample_delay_tap_pkg;

    localparam int SAMPLE_WIDTH = 12;
    localparam int DELAY_DEPTH  = 1024;

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        SEL_RAM    = 2'd0,  // registered RAM read holds the tap
        SEL_BYPASS = 2'd1,  // delay 0: the sample written on the same strobe
        SEL_ZERO   = 2'd2   // tap points at a slot not yet written
    } tap_sel_e;

endpackage : sample_delay_tap_pkg

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM, one write port and one read port, registered read,
// no reset. Maps to a single synchronous block RAM; reusable for reverb lines.
//   clk   : clock, both ports on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata holds its value when low
//   raddr : read address
//   rdata : read data, valid the cycle after re
// A read and a write to the same address in one cycle return the old contents.
// -----------------------------------------------------------------------------
module sdp_ram #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose -- a reset branch would stop it
    // mapping onto block RAM; callers mask unwritten slots themselves.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : sdp_ram

// File: rtl/sample_delay_tap.sv
// -----------------------------------------------------------------------------
// sample_delay_tap
// Circular-buffer delay line read back at a per-sample programmable tap.
// Each enable cycle writes one sample and reads the sample `delay` strobes
// back; the result appears one cycle later with a one-cycle out_valid pulse.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   enable    : sample strobe, one sample in and one out per high cycle
//   in        : sample written on an enable cycle
//   delay     : tap distance 0..DEPTH-1, sampled on enable cycles only
//   out       : delayed sample; 0 when the tap reaches past what was written
//   out_valid : one-cycle pulse, out updated this cycle
//   primed    : high once DEPTH samples have been written since reset
// -----------------------------------------------------------------------------
module sample_delay_tap
    import sample_delay_tap_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH,
    parameter int DEPTH = DELAY_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    delay,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             primed
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW:0]      fill;      // saturating count of samples written
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] bypass_q;
    tap_sel_e         sel_q;
    tap_sel_e         sel_d;

    // Pointer arithmetic wraps in AW bits, giving mod DEPTH for free.
    assign raddr = wptr - delay;

    // A tap reaches a written sample when delay <= fill (the current strobe
    // counts as written). Delay 0 bypasses the RAM so its read-during-write
    // behaviour never matters.
    always_comb begin
        if (delay == '0) begin
            sel_d = SEL_BYPASS;
        end else if ({1'b0, delay} > fill) begin
            sel_d = SEL_ZERO;
        end else begin
            sel_d = SEL_RAM;
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (enable),
        .waddr (wptr),
        .wdata (in),
        .re    (enable),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            fill      <= '0;
            sel_q     <= SEL_ZERO;   // forces out to 0 while and after reset
            bypass_q  <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else begin
            out_valid <= enable;
            if (fill == FULL) begin
                primed <= 1'b1;
            end
            if (enable) begin
                wptr     <= wptr + 1'b1;
                sel_q    <= sel_d;
                bypass_q <= in;
                if (fill != FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    // Select stage aligned with the RAM read latency. Every source is a
    // register that only moves on a strobe, so out holds between strobes.
    // NOTE: out gets a default before the case so no latch is inferred.
    always_comb begin
        out = '0;
        case (sel_q)
            SEL_RAM:    out = ram_q;
            SEL_BYPASS: out = bypass_q;
            default:    out = '0;
        endcase
    end

endmodule : sample_delay_tap

// File: tb/tb_sample_delay_tap.sv
// -----------------------------------------------------------------------------
// tb_sample_delay_tap
// Self-checking bench for sample_delay_tap at DEPTH=8, WIDTH=12. The reference
// keeps the full history of samples written since reset; a strobe with delay d
// returns the sample written d strobes earlier if it exists, else 0.
// -----------------------------------------------------------------------------
module tb_sample_delay_tap;

    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] in;
    logic [AW-1:0]    delay;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             primed;

    sample_delay_tap #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in        (in),
        .delay     (delay),
        .out       (out),
        .out_valid (out_valid),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: every sample written since the last reset, in order.
    logic [WIDTH-1:0] hist [$];
    logic [WIDTH-1:0] last_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, check all outputs.
    task automatic step(input logic en, input logic [WIDTH-1:0] data, input int d);
        logic        exp_primed;
        int          written;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        enable = en;
        in     = data;
        delay  = AW'(d);
        @(posedge clk);
        written    = hist.size();
        // primed reflects the fill reached by the previous edge
        exp_primed = (written >= DEPTH);
        if (en) begin
            if (d == 0) begin
                exp = data;
            end else if (d <= written) begin
                exp = hist[written - d];
            end else begin
                exp = '0;
            end
            hist.push_back(data);
            last_out = exp;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(en));
        check("out", 32'(out), 32'(last_out));
        check("primed", 32'(primed), 32'(exp_primed));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_primed", 32'(primed), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        last_out = '0;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        in       = '0;
        delay    = '0;
        last_out = '0;
        #1;
        check("por_out", 32'(out), 32'd0);
        check("por_out_valid", 32'(out_valid), 32'd0);
        check("por_primed", 32'(primed), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Short stream at delay 2: 0,0,1,2,3
        for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 2);
        step(1'b0, '0, 2);

        // Delay 0 bypass with extreme sample values
        step(1'b1, 12'h7FF, 0);
        step(1'b1, 12'h800, 0);

        // Full-length tap across a pointer wrap
        pulse_reset();
        for (int i = 1; i <= 12; i++) step(1'b1, WIDTH'(i), 7);
        step(1'b0, '0, 7);

        // Strobe gap with a delay change that must be ignored
        pulse_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 3);
        step(1'b0, 12'hABC, 6);
        step(1'b0, 12'hABC, 1);
        step(1'b0, 12'hABC, 6);
        for (int i = 6; i <= 10; i++) step(1'b1, WIDTH'(i), 3);

        // Stale RAM contents masked after a mid-stream reset
        pulse_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1);
        pulse_reset();
        step(1'b1, WIDTH'(9), 4);

        // Delay sweep once primed
        pulse_reset();
        for (int i = 10; i <= 17; i++) step(1'b1, WIDTH'(i), 0);
        step(1'b0, '0, 0);
        step(1'b1, WIDTH'(18), 1);
        step(1'b1, WIDTH'(19), 2);
        step(1'b1, WIDTH'(20), 3);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) != 0, WIDTH'($urandom), int'($urandom_range(0, DEPTH-1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sample_delay_tap
